// File: rtl/ofdm_pkg.sv
`default_nettype none
// ==========================================================================
// ofdm_pkg : OFDM preamble tables (802.11a time domain), lengths, FSM enum
// Rev 1.0
// ==========================================================================
package ofdm_pkg;

  localparam int STS_LEN = 16;
  localparam int LTS_LEN = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STS    = 3'd1,
    S_LTS_GI = 3'd2,
    S_LTS    = 3'd3,
    S_DONE   = 3'd4
  } pre_state_t;

  typedef enum logic {
    SEL_STS = 1'b0,
    SEL_LTS = 1'b1
  } tbl_sel_t;

  // Values in thousandths; scale_q turns them into Q1.(DATA_W-2) at elaboration
  localparam int STS_RE_M [STS_LEN] = '{
    46, -132, -13, 143, 92, 143, -13, -132, 46, 2, -79, -13, 0, -13, -79, 2};
  localparam int STS_IM_M [STS_LEN] = '{
    46, 2, -79, -13, 0, -13, -79, 2, 46, -132, -13, 143, 92, 143, -13, -132};

  localparam int LTS_RE_M [LTS_LEN] = '{
    156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119,
    62, 37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12,
    -156, 12, 92, -92, -3, 75, -127, -122, -35, -56, -60, 70, 82, -131, -57, 37,
    62, 119, -22, 59, 24, -137, 1, 53, 98, -38, -115, 60, 21, 97, 40, -5};
  localparam int LTS_IM_M [LTS_LEN] = '{
    0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -4,
    -62, 98, 39, 65, 92, 14, 81, -22, -151, -17, -21, -74, 54, 115, 106, 98,
    0, -98, -106, -115, -54, 74, 21, 17, 151, 22, -81, -14, -92, -65, -39, -98,
    62, 4, -161, 15, 59, 47, 115, -4, 26, 106, 55, 88, -28, -83, 111, 120};

  // Round half away from zero so positive and negative entries stay symmetric
  function automatic int scale_q(input int milli, input int data_w);
    longint num;
    longint mag;
    num = longint'(milli) * (longint'(1) << (data_w - 2));
    mag = (num < 0) ? -num : num;
    mag = (mag + 64'sd500) / 64'sd1000;
    return (num < 0) ? -int'(mag) : int'(mag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/preamble_rom.sv
`default_nettype none
// ==========================================================================
// preamble_rom : combinational STS/LTS sample lookup, Q1.(DATA_W-2)
// Rev 1.0
// ==========================================================================
module preamble_rom
  import ofdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  tbl_sel_t                 sel,
  input  logic        [5:0]        addr,
  output logic signed [DATA_W-1:0] re,
  output logic signed [DATA_W-1:0] im
);

  logic signed [DATA_W-1:0] w_sts_re [STS_LEN];
  logic signed [DATA_W-1:0] w_sts_im [STS_LEN];
  logic signed [DATA_W-1:0] w_lts_re [LTS_LEN];
  logic signed [DATA_W-1:0] w_lts_im [LTS_LEN];

  for (genvar i = 0; i < STS_LEN; i++) begin : g_sts
    localparam logic signed [DATA_W-1:0] C_RE = DATA_W'(scale_q(STS_RE_M[i], DATA_W));
    localparam logic signed [DATA_W-1:0] C_IM = DATA_W'(scale_q(STS_IM_M[i], DATA_W));
    assign w_sts_re[i] = C_RE;
    assign w_sts_im[i] = C_IM;
  end

  for (genvar i = 0; i < LTS_LEN; i++) begin : g_lts
    localparam logic signed [DATA_W-1:0] C_RE = DATA_W'(scale_q(LTS_RE_M[i], DATA_W));
    localparam logic signed [DATA_W-1:0] C_IM = DATA_W'(scale_q(LTS_IM_M[i], DATA_W));
    assign w_lts_re[i] = C_RE;
    assign w_lts_im[i] = C_IM;
  end

  always_comb begin
    re = w_lts_re[addr];
    im = w_lts_im[addr];
    if (sel == SEL_STS) begin
      re = w_sts_re[addr[3:0]];
      im = w_sts_im[addr[3:0]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/preamble_gen.sv
`default_nettype none
// ==========================================================================
// preamble_gen : STS / LTS-GI / LTS training preamble with ready/valid output
// Rev 1.0
// ==========================================================================
module preamble_gen
  import ofdm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STS_REPS   = 10,
  parameter int LTS_GI_LEN = 32,
  parameter int LTS_REPS   = 2,
  parameter int IDX_W      = $clog2(16*STS_REPS + LTS_GI_LEN + 64*LTS_REPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_clr,
  input  logic                     start_en,
  input  logic                     lts_only,
  input  logic                     train_ready,
  output logic signed [DATA_W-1:0] train_re,
  output logic signed [DATA_W-1:0] train_im,
  output logic                     train_dv,
  output logic        [IDX_W-1:0]  train_index,
  output logic                     train_done,
  output logic                     busy
);

  localparam int         REP_MAX  = (STS_REPS > LTS_REPS) ? STS_REPS : LTS_REPS;
  localparam int         REP_W    = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [5:0] GI_START = 6'(LTS_LEN - LTS_GI_LEN);
  localparam bit         HAS_STS  = (STS_REPS > 0);
  localparam bit         HAS_LTS  = (LTS_REPS > 0);

  pre_state_t               r_state;
  pre_state_t               w_nxt_state;
  logic       [5:0]         r_addr;
  logic       [5:0]         w_nxt_addr;
  logic       [REP_W-1:0]   r_rep;
  logic       [REP_W-1:0]   w_nxt_rep;
  tbl_sel_t                 w_sel;
  logic signed [DATA_W-1:0] w_rom_re;
  logic signed [DATA_W-1:0] w_rom_im;
  logic                     w_xfer;

  assign w_xfer = train_dv && train_ready;

  // Position of the sample that follows the one currently on the output;
  // in IDLE this is the entry point of a new preamble.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_addr  = r_addr + 6'd1;
    w_nxt_rep   = r_rep;
    case (r_state)
      S_IDLE: begin
        w_nxt_rep = '0;
        if (lts_only || !HAS_STS) begin
          w_nxt_state = S_LTS_GI;
          w_nxt_addr  = GI_START;
        end else begin
          w_nxt_state = S_STS;
          w_nxt_addr  = '0;
        end
      end
      S_STS: begin
        if (r_addr == 6'(STS_LEN - 1)) begin
          w_nxt_addr = '0;
          if (int'(r_rep) == STS_REPS - 1) begin
            w_nxt_state = S_LTS_GI;
            w_nxt_addr  = GI_START;
            w_nxt_rep   = '0;
          end else begin
            w_nxt_rep = r_rep + REP_W'(1);
          end
        end
      end
      S_LTS_GI: begin
        if (r_addr == 6'(LTS_LEN - 1)) begin
          w_nxt_addr  = '0;
          w_nxt_rep   = '0;
          w_nxt_state = HAS_LTS ? S_LTS : S_DONE;
        end
      end
      S_LTS: begin
        if (r_addr == 6'(LTS_LEN - 1)) begin
          w_nxt_addr = '0;
          if (int'(r_rep) == LTS_REPS - 1) w_nxt_state = S_DONE;
          else                              w_nxt_rep   = r_rep + REP_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign w_sel = (w_nxt_state == S_STS) ? SEL_STS : SEL_LTS;

  preamble_rom #(
    .DATA_W (DATA_W)
  ) u_rom (
    .sel  (w_sel),
    .addr (w_nxt_addr),
    .re   (w_rom_re),
    .im   (w_rom_im)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || tx_clr) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rep       <= '0;
      train_re    <= '0;
      train_im    <= '0;
      train_dv    <= 1'b0;
      train_index <= '0;
      train_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      train_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_en) begin
            r_state     <= w_nxt_state;
            r_addr      <= w_nxt_addr;
            r_rep       <= w_nxt_rep;
            train_re    <= w_rom_re;
            train_im    <= w_rom_im;
            train_dv    <= 1'b1;
            train_index <= '0;
            busy        <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          // Outputs only move on a transfer, so a stall holds everything
          if (w_xfer) begin
            r_state <= w_nxt_state;
            r_addr  <= w_nxt_addr;
            r_rep   <= w_nxt_rep;
            if (w_nxt_state == S_DONE) begin
              train_dv   <= 1'b0;
              train_done <= 1'b1;
              train_re   <= '0;
              train_im   <= '0;
            end else begin
              train_re    <= w_rom_re;
              train_im    <= w_rom_im;
              train_index <= train_index + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_preamble_gen.sv
`default_nettype none
// ==========================================================================
// tb_preamble_gen : scoreboard bench for preamble_gen (default + 12-bit build)
// Rev 1.0
// ==========================================================================
module tb_preamble_gen;
  import ofdm_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, tx_clr = 1'b0, start_en = 1'b0, lts_only = 1'b0;
  logic train_ready = 1'b1;
  logic signed [7:0] re1, im1;
  logic [8:0] idx1;
  logic dv1, done1, busy1;

  logic start2 = 1'b0, clr2 = 1'b0, lo2 = 1'b0, rdy2 = 1'b1;
  logic signed [11:0] re2, im2;
  logic [6:0] idx2;
  logic dv2, done2, busy2;

  typedef struct { int re; int im; int idx; } exp_t;
  exp_t q1[$], q2[$];

  int  checks = 0, errors = 0, done_cnt1 = 0, done_cnt2 = 0;
  bit  rand_ready = 1'b0;
  int  cap_re[512], cap_im[512], cap2_re[128], cap2_im[128];

  preamble_gen dut (
    .clk(clk), .rst_n(rst_n), .tx_clr(tx_clr), .start_en(start_en), .lts_only(lts_only),
    .train_ready(train_ready), .train_re(re1), .train_im(im1), .train_dv(dv1),
    .train_index(idx1), .train_done(done1), .busy(busy1));

  preamble_gen #(.DATA_W(12), .STS_REPS(2), .LTS_REPS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_clr(clr2), .start_en(start2), .lts_only(lo2),
    .train_ready(rdy2), .train_re(re2), .train_im(im2), .train_dv(dv2),
    .train_index(idx2), .train_done(done2), .busy(busy2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 train_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic void check(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endfunction

  function automatic int q_of(input int milli, input int dw);
    real v;
    v = real'(milli) / 1000.0 * (2.0 ** (dw - 2));
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
  endfunction

  // Reference: the sample list is just the concatenation of the sections
  function automatic void push_model(input bit which, input bit lo, input int sts_reps,
                                     input int lts_reps, input int gi, input int dw);
    int mre[$], mim[$];
    exp_t e;
    if (!lo)
      for (int r = 0; r < sts_reps; r++)
        for (int p = 0; p < STS_LEN; p++) begin
          mre.push_back(STS_RE_M[p]); mim.push_back(STS_IM_M[p]);
        end
    for (int a = LTS_LEN - gi; a < LTS_LEN; a++) begin
      mre.push_back(LTS_RE_M[a]); mim.push_back(LTS_IM_M[a]);
    end
    for (int r = 0; r < lts_reps; r++)
      for (int a = 0; a < LTS_LEN; a++) begin
        mre.push_back(LTS_RE_M[a]); mim.push_back(LTS_IM_M[a]);
      end
    foreach (mre[k]) begin
      e.re = q_of(mre[k], dw); e.im = q_of(mim[k], dw); e.idx = k;
      if (which) q2.push_back(e); else q1.push_back(e);
    end
  endfunction

  logic signed [7:0] p_re, p_im;
  logic [8:0] p_idx;
  bit p_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (p_stall) begin
      check("hold_dv", int'(dv1), 1);
      check("hold_re", int'(re1), int'(p_re));
      check("hold_im", int'(im1), int'(p_im));
      check("hold_idx", int'(idx1), int'(p_idx));
    end
    p_stall = dv1 && !train_ready;
    p_re = re1; p_im = im1; p_idx = idx1;
    if (dv1 && train_ready) begin
      check("sb1_nonempty", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check($sformatf("re1@%0d", e.idx), int'(re1), e.re);
        check($sformatf("im1@%0d", e.idx), int'(im1), e.im);
        check($sformatf("idx1@%0d", e.idx), int'(idx1), e.idx);
        cap_re[idx1] = re1; cap_im[idx1] = im1;
      end
    end
    if (done1) begin
      done_cnt1++;
      check("done1_sb_empty", q1.size(), 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (dv2) begin
      check("sb2_nonempty", int'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check($sformatf("re2@%0d", e.idx), int'(re2), e.re);
        check($sformatf("im2@%0d", e.idx), int'(im2), e.im);
        check($sformatf("idx2@%0d", e.idx), int'(idx2), e.idx);
        cap2_re[idx2] = re2; cap2_im[idx2] = im2;
      end
    end
    if (done2) begin
      done_cnt2++;
      check("done2_sb_empty", q2.size(), 0);
    end
  end

  task automatic start1(input bit lo);
    @(negedge clk); start_en = 1'b1; lts_only = lo;
    @(posedge clk); #1 start_en = 1'b0; lts_only = 1'b0;
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    while (!done1 && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (cyc == 1) check("busy_first_sample", int'(busy1), 1);
    end
    check("done1_seen", int'(done1), 1);
    check("busy_in_done", int'(busy1), 1);
  endtask

  task automatic tail1(input bit poke_start);
    start_en = poke_start;
    @(posedge clk); #1 start_en = 1'b0;
    @(negedge clk);
    check("busy_after_done", int'(busy1), 0);
    check("dv_after_done", int'(dv1), 0);
    check("done_single_cycle", int'(done1), 0);
  endtask

  task automatic wait_index(input int target);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(dv1 && int'(idx1) == target) && n < 2000);
    check($sformatf("reach_idx_%0d", target), int'(dv1 && int'(idx1) == target), 1);
  endtask

  task automatic check_idle1(input string tag);
    check({tag, "_dv"}, int'(dv1), 0);
    check({tag, "_busy"}, int'(busy1), 0);
    check({tag, "_done"}, int'(done1), 0);
    check({tag, "_re"}, int'(re1), 0);
    check({tag, "_im"}, int'(im1), 0);
    check({tag, "_idx"}, int'(idx1), 0);
  endtask

  initial begin
    int cyc, d0;
    repeat (2) @(posedge clk);
    #1;
    check_idle1("reset");
    check("reset2_dv", int'(dv2), 0);
    check("reset2_busy", int'(busy2), 0);
    rst_n = 1'b1;

    // Full preamble, no stalls
    d0 = done_cnt1;
    push_model(0, 0, 10, 2, 32, 8);
    start1(0); wait_done1(cyc);
    check("s1_cycles", cyc, 321);
    tail1(0);
    check("s1_done_count", done_cnt1 - d0, 1);
    check("s1_i0_re", cap_re[0], 3);     check("s1_i0_im", cap_im[0], 3);
    check("s1_i16_re", cap_re[16], 3);   check("s1_i16_im", cap_im[16], 3);
    check("s1_i160_re", cap_re[160], -10); check("s1_i160_im", cap_im[160], 0);
    check("s1_i192_re", cap_re[192], 10);  check("s1_i192_im", cap_im[192], 0);
    check("s1_i256_re", cap_re[256], 10);  check("s1_i256_im", cap_im[256], 0);

    // LTS-only
    push_model(0, 1, 10, 2, 32, 8);
    start1(1); wait_done1(cyc);
    check("lo_cycles", cyc, 161);
    tail1(0);
    check("lo_i0_re", cap_re[0], -10); check("lo_i0_im", cap_im[0], 0);
    check("lo_i32_re", cap_re[32], 10); check("lo_i32_im", cap_im[32], 0);

    // Random backpressure
    rand_ready = 1'b1;
    push_model(0, 0, 10, 2, 32, 8);
    start1(0); wait_done1(cyc);
    rand_ready = 1'b0;
    check("stall_seen", int'(cyc > 321), 1);
    tail1(0);

    // Abort mid-STS, then restart
    push_model(0, 0, 10, 2, 32, 8);
    start1(0); wait_index(100);
    tx_clr = 1'b1;
    @(posedge clk); #1 tx_clr = 1'b0;
    check_idle1("clr");
    q1.delete();
    d0 = done_cnt1;
    repeat (5) @(negedge clk);
    check("clr_no_done", done_cnt1 - d0, 0);
    foreach (cap_re[i]) begin cap_re[i] = -999; cap_im[i] = -999; end
    push_model(0, 0, 10, 2, 32, 8);
    start1(0); wait_done1(cyc);
    check("restart_cycles", cyc, 321);
    tail1(0);
    check("restart_i0_re", cap_re[0], 3); check("restart_i0_im", cap_im[0], 3);

    // start_en while busy and during DONE is ignored
    d0 = done_cnt1;
    push_model(0, 0, 10, 2, 32, 8);
    start1(0); wait_index(50);
    start_en = 1'b1;
    @(posedge clk); #1 start_en = 1'b0;
    wait_done1(cyc);
    check("ign_cycles", cyc, 270);
    tail1(1);
    repeat (3) @(negedge clk);
    check("ign_still_idle", int'(busy1), 0);
    check("ign_done_count", done_cnt1 - d0, 1);

    // tx_clr beats start_en in IDLE
    @(negedge clk); start_en = 1'b1; tx_clr = 1'b1;
    @(posedge clk); #1 start_en = 1'b0; tx_clr = 1'b0;
    check_idle1("clr_start");
    repeat (3) @(negedge clk);
    check("clr_start_later_busy", int'(busy1), 0);

    // Reset pulse mid-LTS
    push_model(0, 0, 10, 2, 32, 8);
    start1(0); wait_index(200);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check_idle1("rst_mid");
    q1.delete();
    repeat (3) @(negedge clk);
    check("rst_mid_later_dv", int'(dv1), 0);

    // Alternate build: STS_REPS=2, LTS_REPS=1, DATA_W=12
    push_model(1, 0, 2, 1, 32, 12);
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("d2_done_seen", int'(done2), 1);
    check("d2_cycles", cyc, 129);
    @(negedge clk);
    check("d2_busy_after", int'(busy2), 0);
    check("d2_done_count", done_cnt2, 1);
    check("d2_i0_re", cap2_re[0], 47);    check("d2_i0_im", cap2_im[0], 47);
    check("d2_i32_re", cap2_re[32], -160); check("d2_i64_re", cap2_re[64], 160);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/preamble_gen.md
# preamble_gen

Parametrised OFDM training-preamble generator: emits a configurable number of short-training-symbol (STS) periods, the long-training guard interval (LTS GI), then a configurable number of long-training-symbol (LTS) periods as one contiguous complex sample stream. It adds ready/valid backpressure, an LTS-only mode, abort and a busy flag. It sits at the head of the transmit chain and feeds the same downstream mux/IFFT-bypass path that consumes data symbols.

## Interface
- DATA_W, 8: signed width of each I/Q sample; table values are Q1.(DATA_W-2).
- STS_REPS, 10: number of 16-sample STS periods.
- LTS_GI_LEN, 32: LTS guard length (1..64); it is the last LTS_GI_LEN samples of the 64-sample LTS.
- LTS_REPS, 2: number of 64-sample LTS periods.
- IDX_W, derived as $clog2(16*STS_REPS+LTS_GI_LEN+64*LTS_REPS): train_index width; 9 with defaults.
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- tx_clr  in  1  synchronous abort/clear.
- start_en  in  1  start request; level-sampled and accepted only in IDLE.
- lts_only  in  1  sampled with start_en; 1 skips the STS section.
- train_ready  in  1  downstream ready.
- train_re  out  DATA_W  real sample, signed.
- train_im  out  DATA_W  imaginary sample, signed.
- train_dv  out  1  sample valid.
- train_index  out  IDX_W  running sample number within the preamble.
- train_done  out  1  one-cycle pulse after the final sample transfers.
- busy  out  1  high from the accept cycle until the done pulse, inclusive.

## Operation
- States: IDLE, STS, LTS_GI, LTS, DONE.
- IDLE -> STS on start_en when lts_only=0; IDLE -> LTS_GI when lts_only=1.
- STS: period counter p (0..15) and repetition counter r. After transfer of p=15 with r=STS_REPS-1, the FSM goes to LTS_GI.
- LTS_GI: LTS table address runs from 64-LTS_GI_LEN to 63, then the FSM goes to LTS.
- LTS: address 0..63 for each of LTS_REPS periods, then the FSM goes to DONE.
- DONE lasts one cycle: train_done=1, busy=1, then IDLE.
- A transfer happens when train_dv && train_ready. Counters, index and address advance only on a transfer.
- When train_dv=1 and train_ready=0, train_re, train_im and train_index hold stable.
- train_index starts at 0 on every accepted start and increments by 1 per transfer across section boundaries.
  - Total count is 16*STS_REPS+LTS_GI_LEN+64*LTS_REPS, or LTS_GI_LEN+64*LTS_REPS with lts_only.
  - No wrap: the final index is total-1.
- start_en while busy is ignored; it is neither queued nor restarts the sequence.
- tx_clr (any state): next cycle the FSM is in IDLE with all outputs at reset values and no train_done. This is identical to reset.
  - tx_clr and start_en in the same cycle: tx_clr wins and the start is dropped.
- Priority: rst_n > tx_clr > start_en.
- Zero-width sections (STS_REPS=0, LTS_REPS=0) are skipped without an empty cycle.

## Timing
- Reset values (rst_n=0 at an edge): state IDLE, train_re=0, train_im=0, train_dv=0, train_index=0, train_done=0, busy=0.
- All outputs are registered.
- start_en accepted at edge N: busy=1 and train_dv=1 with index 0 after edge N. The first sample is visible in cycle N+1.
- With train_ready held at 1, there is one sample per cycle and no bubbles at section boundaries.
- The last transfer at edge M gives train_dv=0 and train_done=1 after edge M, and busy=0 after edge M+1.
- A new start_en is accepted once busy=0. The minimum gap between two preambles is 2 cycles of train_dv=0.

## Structure
- Shared package ofdm_pkg holds:
  - STS 16-entry and LTS 64-entry tables (standard 802.11a time-domain values, Q1.6 at DATA_W=8, scaled by 2^(DATA_W-2) and rounded);
  - localparams STS_LEN=16 and LTS_LEN=64;
  - the state enum.
- One sub-module, preamble_rom: combinational lookup. Inputs are sel (STS/LTS) and a 6-bit address; outputs are re and im. It is instantiated once.
- Top level contains the FSM, counters, output register and hold logic.

## Test plan
- Defaults, train_ready=1, start_en pulse:
  - 320 contiguous samples, index 0..319;
  - sample 0 = (3,3), sample 16 = (3,3);
  - sample 160 = LTS[32]; sample 192 = (10,0); sample 256 = (10,0);
  - train_done pulses once after index 319.
- lts_only=1: 160 samples; index 0 = LTS[32], index 32 = (10,0); done after index 159.
- Random train_ready stalls (about 50%): the output sequence is identical to the no-stall run, and values and index hold during every stall.
- tx_clr asserted at index 100 (mid-STS): train_dv=0 and busy=0 next cycle, and no train_done. A following start restarts at index 0 with (3,3).
- start_en pulsed at index 50 and during DONE: both are ignored, and the sequence and done pulse are unchanged. start_en and tx_clr in the same cycle in IDLE: no start.
- rst_n=0 for one cycle mid-LTS: all outputs are at reset values after that edge. Also rerun the first scenario with STS_REPS=2, LTS_REPS=1, DATA_W=12 and check 128 samples.
